serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
//  Downstream stage of the 1-bit resumption machine: samples its serial output
//  (out0, qualified by continue) and frames it into WORD_W-bit words.
//  Completed words are buffered in a 2-entry FIFO and offered on a valid/ready port
//  to the word-level consumer.
//  The upstream machine cannot stall, so back-pressure shows up as dropped words
//  and a sticky overflow flag.
// PARAMETERS
//  WORD_W     8  data bits per frame (2..32)
//  MSB_FIRST  1  1: first data bit lands in word_o[WORD_W-1]; 0: it lands in word_o[0]
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset
//  bit_i      in   1       serial data (upstream out0)
//  bit_vld_i  in   1       bit_i valid this cycle (upstream continue)
//  word_o     out  WORD_W  head-of-FIFO word
//  word_vld_o out  1       FIFO non-empty
//  word_rdy_i in   1       consumer accepts word_o when word_vld_o&&word_rdy_i
//  par_err_o  out  1       parity error flag of head word (DESER_PARITY_EN only, else tied 0)
//  overflow_o out  1       sticky: a completed word was dropped because the FIFO was full
//  busy_o     out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, bit count=0, FIFO empty, and all outputs 0.
//  Cycles with bit_vld_i=0 are ignored entirely; the FSM holds its state.
//  FSM (advances only on bit_vld_i=1):
//   IDLE: bit_i=1 is the start bit -> DATA with cnt=0; bit_i=0 stays in IDLE.
//   DATA: shift bit_i in per MSB_FIRST and increment cnt.
//         On the WORD_W-th bit -> PAR if DESER_PARITY_EN, else COMMIT.
//   PAR : capture the parity bit -> COMMIT.
//   COMMIT is not a state: the push happens on the same edge as the last data/parity bit,
//         and the FSM goes to IDLE. A start bit is accepted on the very next valid cycle.
//  Latency: word_vld_o rises the cycle after the edge that carries the final bit,
//   provided the FIFO had space.
//  FIFO: 2 entries, first-word fall-through (registered head).
//   Pop when word_vld_o && word_rdy_i.
//   Push and pop in the same cycle when full: both occur, no drop, count stays 2.
//   Push when full with no pop: the word is discarded and overflow_o <= 1 until reset.
//   FIFO contents are never overwritten.
//  word_o holds its value while word_vld_o=1 && word_rdy_i=0.
//  word_o is don't-care while empty; drive 0.
//  An async reset mid-frame discards the partial word. The next frame needs a fresh start bit.
//  Count width: $clog2(WORD_W+1); no wrap, the counter is cleared at commit.
// CONFIGURATION
//  DESER_PARITY_EN defined:
//   - frame is start + WORD_W data bits + 1 even-parity bit;
//   - par_err_o = (^data) ^ parity_bit, stored per FIFO entry alongside the word;
//   - erroneous words are still delivered.
//  DESER_PARITY_EN undefined:
//   - no PAR state; frame is start + WORD_W data bits;
//   - par_err_o driven 0 and no parity storage is synthesized.
// STRUCTURE
//  Package serial_word_pkg:
//   - typedef enum logic [1:0] {IDLE, DATA, PAR} col_state_t;
//   - localparam FIFO_DEPTH = 2;
//   - typedef struct packed {word, par_err} fifo_entry_t.
//  Sub-module word_fifo2 (2-entry valid/ready FIFO with a full/overflow indication).
//   The top holds the FSM and shift register.
// TESTING
//  1 WORD_W=8, MSB_FIRST=1, rdy=1: serial 1,1,0,1,0,0,1,0,1 (vld=1)
//    -> word_o=8'hA5 with word_vld_o high for 1 cycle, the cycle after bit 9.
//  2 Same frame with bit_vld_i=0 on alternate cycles -> identical 8'hA5 and no spurious push.
//  3 rdy=0; send 8'h01, 8'h02, 8'h03 -> FIFO holds 01,02; 03 dropped; overflow_o=1.
//    Then rdy=1 -> pops 01 then 02; overflow_o stays 1.
//  4 FIFO full, and the last bit of 8'h55 arrives on the same cycle as a pop
//    -> no drop; sequence out is 01, 02, 55.
//  5 rst=0 asserted after 4 data bits, then released; send start + 8'h3C
//    -> only 8'h3C is delivered and all flags are 0.
//  6 DESER_PARITY_EN: frame 8'h07 with parity 1 -> par_err_o=0;
//    the same frame with parity 0 -> par_err_o=1.
//    MSB_FIRST=0 variant of scenario 1 -> word_o=8'hA5 bit-reversed (8'hA5 -> 8'hA5 is
//    palindromic), so use 8'h01 -> 8'h80.

Source files
------------

// File: rtl/serial_word_pkg.sv
// +----------------------------------------------------------------------------+
// | serial_word_pkg                                                            |
// | Shared types and constants for the serial word collector.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } col_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_WORD_W = 32;

  typedef struct packed {
    logic [MAX_WORD_W-1:0] word;
    logic                  par_err;
  } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/word_fifo2.sv
// +----------------------------------------------------------------------------+
// | word_fifo2                                                                 |
// | Two-entry first-word fall-through FIFO with sticky overflow on drop.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module word_fifo2
  import serial_word_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              rdy_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  output logic              overflow_o
);

  localparam logic [1:0] c_full = 2'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_count;
  logic              r_overflow;
  logic              w_pop;
  logic              w_full;
  logic              w_accept;
  logic              w_drop;

  assign vld_o      = (r_count != 2'd0);
  assign w_full     = (r_count == c_full);
  assign w_pop      = vld_o && rdy_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO survives.
  assign w_accept   = push_i && (!w_full || w_pop);
  assign w_drop     = push_i && w_full && !w_pop;
  assign data_o     = vld_o ? r_head : '0;
  assign overflow_o = r_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_pop, w_accept})
        2'b11: begin
          if (r_count == c_full) begin
            r_head <= r_tail;
            r_tail <= push_data_i;
          end else begin
            r_head <= push_data_i;
          end
        end
        2'b10: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd0) begin
            r_head <= push_data_i;
          end else begin
            r_tail <= push_data_i;
          end
          r_count <= r_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_word_collector.sv
// +----------------------------------------------------------------------------+
// | serial_word_collector                                                      |
// | Frames a qualified serial bit stream into words and buffers them in a      |
// | 2-entry FIFO. Define DESER_PARITY_EN to add an even-parity bit per frame.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_word_collector
  import serial_word_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_i,
  input  logic              bit_vld_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o,
  input  logic              word_rdy_i,
  output logic              par_err_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int                c_cnt_w    = $clog2(WORD_W + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WORD_W - 1);
`ifdef DESER_PARITY_EN
  localparam int                c_fifo_w   = WORD_W + 1;
`else
  localparam int                c_fifo_w   = WORD_W;
`endif

  col_state_t          r_state;
  col_state_t          w_state_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_next;
  logic [WORD_W-1:0]   r_shift;
  logic [WORD_W-1:0]   w_shift_next;
  logic [WORD_W-1:0]   w_shift_in;
  logic                w_push;
  logic [c_fifo_w-1:0] w_push_data;
  logic [c_fifo_w-1:0] w_fifo_data;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_in = {r_shift[WORD_W-2:0], bit_i};
    end else begin : g_lsb_first
      assign w_shift_in = {bit_i, r_shift[WORD_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
    end
  end

  // The commit push is combinational so the FIFO captures on the final-bit edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_push       = 1'b0;
    if (bit_vld_i) begin
      case (r_state)
        IDLE: begin
          if (bit_i) begin
            w_state_next = DATA;
            w_cnt_next   = '0;
          end
        end
        DATA: begin
          w_shift_next = w_shift_in;
          w_cnt_next   = r_cnt + 1'b1;
          if (r_cnt == c_last_bit) begin
            w_cnt_next = '0;
`ifdef DESER_PARITY_EN
            w_state_next = PAR;
`else
            w_state_next = IDLE;
            w_push       = 1'b1;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        PAR: begin
          w_state_next = IDLE;
          w_push       = 1'b1;
        end
`endif
        default: w_state_next = IDLE;
      endcase
    end
  end

`ifdef DESER_PARITY_EN
  assign w_push_data = {(^r_shift) ^ bit_i, r_shift};
  assign par_err_o   = w_fifo_data[WORD_W];
`else
  assign w_push_data = w_shift_in;
  assign par_err_o   = 1'b0;
`endif
  assign word_o = w_fifo_data[WORD_W-1:0];
  assign busy_o = (r_state != IDLE);

  word_fifo2 #(
    .DATA_W (c_fifo_w)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .rdy_i       (word_rdy_i),
    .data_o      (w_fifo_data),
    .vld_o       (word_vld_o),
    .overflow_o  (overflow_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_serial_word_collector.sv
// +----------------------------------------------------------------------------+
// | tb_serial_word_collector                                                   |
// | Scoreboard bench for serial_word_collector (MSB-first and LSB-first DUTs). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_i;
  logic       bit_vld;
  logic       word_rdy;
  logic [7:0] word;
  logic       word_vld;
  logic       par_err;
  logic       overflow;
  logic       busy;
  logic [7:0] l_word;
  logic       l_word_vld;
  logic       l_par_err;
  logic       l_overflow;
  logic       l_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_word_collector #(.WORD_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_vld_i(bit_vld),
    .word_o(word), .word_vld_o(word_vld), .word_rdy_i(word_rdy),
    .par_err_o(par_err), .overflow_o(overflow), .busy_o(busy)
  );

  serial_word_collector #(.WORD_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_vld_i(bit_vld),
    .word_o(l_word), .word_vld_o(l_word_vld), .word_rdy_i(1'b1),
    .par_err_o(l_par_err), .overflow_o(l_overflow), .busy_o(l_busy)
  );

  // Scoreboard: every accepted word must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && word_vld === 1'b1 && word_rdy === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_spurious: got par/word=%h, required no word", {par_err, word});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({par_err, word} !== e) begin
          n_fail++;
          $display("FAIL pop_word: got par/word=%h, required %h", {par_err, word}, e);
        end
      end
    end
  end

  function automatic logic [8:0] exp_of(input logic [7:0] w, input logic par);
`ifdef DESER_PARITY_EN
    return {(^w) ^ par, w};
`else
    return {1'b0, w};
`endif
  endfunction

  task automatic drive(input logic b, input logic v);
    bit_i   = b;
    bit_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic par, input bit gap, input bit rdy_last);
    if (gap) drive(1'($urandom_range(0, 1)), 1'b0);
    drive(1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      if (gap) drive(1'($urandom_range(0, 1)), 1'b0);
`ifndef DESER_PARITY_EN
      if (rdy_last && i == 0) word_rdy = 1'b1;
`endif
      drive(w[i], 1'b1);
    end
`ifdef DESER_PARITY_EN
    if (gap) drive(1'($urandom_range(0, 1)), 1'b0);
    if (rdy_last) word_rdy = 1'b1;
    drive(par, 1'b1);
`endif
    bit_i   = 1'b0;
    bit_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_i = 1'b0; bit_vld = 1'b0; word_rdy = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (word !== 8'h00)   begin n_fail++; $display("FAIL reset_word: got %h, required 00", word); end
    n_tests++; if (word_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b, required 0", word_vld); end
    n_tests++; if (par_err !== 1'b0)  begin n_fail++; $display("FAIL reset_par: got %b, required 0", par_err); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", overflow); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b1;
    drive(1'b0, 1'b0);
  endtask

  task automatic test_basic();
    word_rdy = 1'b1;
    exp_q.push_back(exp_of(8'hA5, ^8'hA5));
    send_frame(8'hA5, ^8'hA5, 1'b0, 1'b0);
    n_tests++; if (word_vld !== 1'b1 || word !== 8'hA5) begin
      n_fail++; $display("FAIL basic_latency: got vld=%b word=%h, required vld=1 word=a5", word_vld, word);
    end
    drive(1'b0, 1'b0);
    n_tests++; if (word_vld !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got vld=%b, required 0", word_vld); end
  endtask

  task automatic test_gaps();
    word_rdy = 1'b1;
    exp_q.push_back(exp_of(8'hA5, ^8'hA5));
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
    n_tests++; if (word_vld !== 1'b1 || word !== 8'hA5) begin
      n_fail++; $display("FAIL gaps_word: got vld=%b word=%h, required vld=1 word=a5", word_vld, word);
    end
    wait_drain();
    n_tests++; if (exp_q.size() !== 0 || word_vld !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL gaps_drain: got left=%0d vld=%b busy=%b, required 0 0 0", exp_q.size(), word_vld, busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    word_rdy = 1'b0;
    exp_q.push_back(exp_of(8'h01, ^8'h01));
    exp_q.push_back(exp_of(8'h02, ^8'h02));
    send_frame(8'h01, ^8'h01, 1'b0, 1'b0);
    send_frame(8'h02, ^8'h02, 1'b0, 1'b0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b, required 0", overflow); end
    send_frame(8'h03, ^8'h03, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    n_tests++; if (word_vld !== 1'b1 || word !== 8'h01) begin
      n_fail++; $display("FAIL ovf_hold: got vld=%b word=%h, required vld=1 word=01", word_vld, word);
    end
    word_rdy = 1'b1;
    wait_drain();
    n_tests++; if (exp_q.size() !== 0 || word_vld !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain: got left=%0d vld=%b, required 0 0", exp_q.size(), word_vld);
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    word_rdy = 1'b0;
    exp_q.push_back(exp_of(8'h01, ^8'h01));
    exp_q.push_back(exp_of(8'h02, ^8'h02));
    exp_q.push_back(exp_of(8'h55, ^8'h55));
    send_frame(8'h01, ^8'h01, 1'b0, 1'b0);
    send_frame(8'h02, ^8'h02, 1'b0, 1'b0);
    send_frame(8'h55, ^8'h55, 1'b0, 1'b1);
    n_tests++; if (word_vld !== 1'b1 || word !== 8'h02) begin
      n_fail++; $display("FAIL b2b_head: got vld=%b word=%h, required vld=1 word=02", word_vld, word);
    end
    wait_drain();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_drain: got left=%0d, required 0", exp_q.size()); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b, required 0", overflow); end
  endtask

  task automatic test_reset_midframe();
    word_rdy = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    bit_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || word_vld !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got busy=%b vld=%b, required 0 0", busy, word_vld);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(exp_of(8'h3C, ^8'h3C));
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
    wait_drain();
    n_tests++; if (exp_q.size() !== 0 || overflow !== 1'b0 || par_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got left=%0d ovf=%b par=%b busy=%b, required 0 0 0 0",
                         exp_q.size(), overflow, par_err, busy);
    end
  endtask

  task automatic test_parity();
    word_rdy = 1'b1;
    exp_q.push_back(exp_of(8'h07, 1'b1));
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b, required 0", par_err); end
    exp_q.push_back(exp_of(8'h07, 1'b0));
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
`ifdef DESER_PARITY_EN
    n_tests++; if (par_err !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b, required 1", par_err); end
`else
    n_tests++; if (par_err !== 1'b0) begin n_fail++; $display("FAIL par_tied: got %b, required 0", par_err); end
`endif
    wait_drain();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL par_drain: got left=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_lsb_first();
    word_rdy = 1'b1;
    exp_q.push_back(exp_of(8'h01, ^8'h01));
    send_frame(8'h01, ^8'h01, 1'b0, 1'b0);
    n_tests++; if (l_word_vld !== 1'b1 || l_word !== 8'h80) begin
      n_fail++; $display("FAIL lsb_word: got vld=%b word=%h, required vld=1 word=80", l_word_vld, l_word);
    end
    n_tests++; if (l_overflow !== 1'b0 || l_par_err !== 1'b0 || l_busy !== 1'b0) begin
      n_fail++; $display("FAIL lsb_flags: got ovf=%b par=%b busy=%b, required 0 0 0", l_overflow, l_par_err, l_busy);
    end
    wait_drain();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL lsb_drain: got left=%0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    test_lsb_first();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
